// File: rtl/usb_transaction_ctrl_pkg.sv
// Shared USB device types: PID encodings, token bundle,
// transaction controller states and PID helpers.
package usb_transaction_ctrl_pkg;

  typedef enum logic [3:0] {
    PID_RESERVED = 4'b0000,
    PID_OUT      = 4'b0001,
    PID_ACK      = 4'b0010,
    PID_DATA0    = 4'b0011,
    PID_SOF      = 4'b0101,
    PID_IN       = 4'b1001,
    PID_NAK      = 4'b1010,
    PID_DATA1    = 4'b1011,
    PID_SETUP    = 4'b1101,
    PID_STALL    = 4'b1110
  } pid_t;

  typedef struct packed {
    pid_t       pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } token_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_SEND_HS,
    ST_SEND_DATA,
    ST_WAIT_HS
  } ctrl_state_t;

  function automatic logic is_data_pid(input pid_t p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic pid_t data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_timeout_cnt.sv
// Inactivity timer: cleared by load, counts while enabled,
// flags expiry on the TIMEOUT-th enabled cycle.
module usb_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear on load, advance while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_transaction_ctrl.sv
// Low-speed USB device transaction sequencer: token
// qualification, data toggles, handshake and buffer control.
module usb_transaction_ctrl
  import usb_transaction_ctrl_pkg::*;
#(
  parameter int NUM_ENDP = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bus_reset,
  input  logic [6:0]          dev_addr,
  input  logic                rx_tok_valid,
  input  logic [3:0]          rx_tok_pid,
  input  logic [6:0]          rx_tok_addr,
  input  logic [3:0]          rx_tok_endp,
  input  logic                rx_tok_crc_ok,
  input  logic                rx_data_valid,
  input  logic [3:0]          rx_data_pid,
  input  logic                rx_data_ok,
  input  logic [NUM_ENDP-1:0] ep_stall,
  input  logic [NUM_ENDP-1:0] ep_in_ready,
  input  logic [NUM_ENDP-1:0] ep_out_ready,
  output logic                tx_req,
  output logic [3:0]          tx_pid,
  output logic                tx_with_data,
  input  logic                tx_done,
  output logic [3:0]          xfer_endp,
  output logic                setup_rcvd,
  output logic                out_commit,
  output logic                out_discard,
  output logic                in_ack,
  output logic                in_retry
);

  // Bus reset behaves exactly like the system reset.
  logic rst_n;
  assign rst_n = reset_n & ~bus_reset;

  token_t tok;
  pid_t   dpid;
  assign tok.pid  = pid_t'(rx_tok_pid);
  assign tok.addr = rx_tok_addr;
  assign tok.endp = rx_tok_endp;
  assign dpid     = pid_t'(rx_data_pid);

  ctrl_state_t         state_q, state_d;
  logic                setup_q, setup_d;
  logic [3:0]          endp_q, endp_d;
  logic [NUM_ENDP-1:0] tog_q, tog_d;
  logic                tx_req_q, tx_req_d;
  pid_t                tx_pid_q, tx_pid_d;
  logic                tx_data_q, tx_data_d;
  logic                setup_rcvd_q, setup_rcvd_d;
  logic                commit_q, commit_d;
  logic                discard_q, discard_d;
  logic                in_ack_q, in_ack_d;
  logic                in_retry_q, in_retry_d;

  logic                tmr_load, tmr_en, tmr_exp;
  logic [NUM_ENDP-1:0] e_sel, t_sel;
  logic                cur_tog, stall_e, out_rdy;
  logic                tok_stall, tok_rdy, tok_tog;
  logic                tok_ok, pid_ok;
  logic                hs_go;
  pid_t                hs_pid;

  // One-hot selects for the latched and incoming endpoint.
  always_comb begin
    e_sel = '0;
    t_sel = '0;
    for (int i = 0; i < NUM_ENDP; i++) begin
      e_sel[i] = (endp_q == 4'(i));
      t_sel[i] = (rx_tok_endp == 4'(i));
    end
  end

  assign cur_tog   = |(tog_q & e_sel);
  assign stall_e   = |(ep_stall & e_sel);
  assign out_rdy   = |(ep_out_ready & e_sel);
  assign tok_stall = |(ep_stall & t_sel);
  assign tok_rdy   = |(ep_in_ready & t_sel);
  assign tok_tog   = |(tog_q & t_sel);

  assign pid_ok = (tok.pid == PID_OUT)
               || (tok.pid == PID_IN)
               || (tok.pid == PID_SETUP);

  assign tok_ok = rx_tok_valid
               && rx_tok_crc_ok
               && (tok.addr == dev_addr)
               && ({1'b0, tok.endp} < 5'(NUM_ENDP))
               && pid_ok;

  assign tmr_en = (state_q == ST_WAIT_DATA)
               || (state_q == ST_WAIT_HS);

  usb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  // Next-state, toggle, transmit request and pulse decisions.
  always_comb begin
    state_d      = state_q;
    setup_d      = setup_q;
    endp_d       = endp_q;
    tog_d        = tog_q;
    tx_req_d     = tx_req_q;
    tx_pid_d     = tx_pid_q;
    tx_data_d    = tx_data_q;
    setup_rcvd_d = 1'b0;
    commit_d     = 1'b0;
    discard_d    = 1'b0;
    in_ack_d     = 1'b0;
    in_retry_d   = 1'b0;
    tmr_load     = 1'b0;
    hs_go        = 1'b0;
    hs_pid       = PID_ACK;

    unique case (state_q)
      ST_IDLE: begin
        if (tok_ok) begin
          endp_d   = tok.endp;
          tmr_load = 1'b1;
          if (tok.pid == PID_IN) begin
            if (tok_stall) begin
              hs_go  = 1'b1;
              hs_pid = PID_STALL;
            end else if (!tok_rdy) begin
              hs_go  = 1'b1;
              hs_pid = PID_NAK;
            end else begin
              state_d   = ST_SEND_DATA;
              tx_req_d  = 1'b1;
              tx_pid_d  = data_pid(tok_tog);
              tx_data_d = 1'b1;
            end
          end else begin
            state_d = ST_WAIT_DATA;
            setup_d = (tok.pid == PID_SETUP);
          end
        end
      end

      ST_WAIT_DATA: begin
        if (rx_data_valid) begin
          if (!rx_data_ok || !is_data_pid(dpid)) begin
            state_d   = ST_IDLE;
            discard_d = 1'b1;
          end else if (setup_q) begin
            if (dpid == PID_DATA0) begin
              tog_d        = tog_q | e_sel;
              setup_rcvd_d = 1'b1;
              hs_go        = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              discard_d = 1'b1;
            end
          end else if (stall_e) begin
            hs_go     = 1'b1;
            hs_pid    = PID_STALL;
            discard_d = 1'b1;
          end else if (!out_rdy) begin
            hs_go     = 1'b1;
            hs_pid    = PID_NAK;
            discard_d = 1'b1;
          end else if (dpid == data_pid(cur_tog)) begin
            hs_go    = 1'b1;
            commit_d = 1'b1;
            tog_d    = tog_q ^ e_sel;
          end else begin
            hs_go     = 1'b1;
            discard_d = 1'b1;
          end
        end else if (tmr_exp) begin
          state_d   = ST_IDLE;
          discard_d = 1'b1;
        end
      end

      ST_SEND_HS: begin
        if (tx_done) begin
          state_d   = ST_IDLE;
          tx_req_d  = 1'b0;
          tx_data_d = 1'b0;
        end
      end

      ST_SEND_DATA: begin
        if (tx_done) begin
          state_d   = ST_WAIT_HS;
          tx_req_d  = 1'b0;
          tx_data_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end

      ST_WAIT_HS: begin
        if (rx_data_valid) begin
          state_d = ST_IDLE;
          if (rx_data_ok && (dpid == PID_ACK)) begin
            tog_d    = tog_q ^ e_sel;
            in_ack_d = 1'b1;
          end else begin
            in_retry_d = 1'b1;
          end
        end else if (tmr_exp) begin
          state_d    = ST_IDLE;
          in_retry_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (hs_go) begin
      state_d   = ST_SEND_HS;
      tx_req_d  = 1'b1;
      tx_pid_d  = hs_pid;
      tx_data_d = 1'b0;
    end
  end

  // State, toggle and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      setup_q      <= 1'b0;
      endp_q       <= '0;
      tog_q        <= '0;
      tx_req_q     <= 1'b0;
      tx_pid_q     <= PID_RESERVED;
      tx_data_q    <= 1'b0;
      setup_rcvd_q <= 1'b0;
      commit_q     <= 1'b0;
      discard_q    <= 1'b0;
      in_ack_q     <= 1'b0;
      in_retry_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      setup_q      <= setup_d;
      endp_q       <= endp_d;
      tog_q        <= tog_d;
      tx_req_q     <= tx_req_d;
      tx_pid_q     <= tx_pid_d;
      tx_data_q    <= tx_data_d;
      setup_rcvd_q <= setup_rcvd_d;
      commit_q     <= commit_d;
      discard_q    <= discard_d;
      in_ack_q     <= in_ack_d;
      in_retry_q   <= in_retry_d;
    end
  end

  assign tx_req       = tx_req_q;
  assign tx_pid       = tx_pid_q;
  assign tx_with_data = tx_data_q;
  assign xfer_endp    = endp_q;
  assign setup_rcvd   = setup_rcvd_q;
  assign out_commit   = commit_q;
  assign out_discard  = discard_q;
  assign in_ack       = in_ack_q;
  assign in_retry     = in_retry_q;

endmodule

// File: tb/tb_usb_transaction_ctrl.sv
// Self-checking bench for usb_transaction_ctrl: directed and
// random transactions against a transaction-level model.
module tb_usb_transaction_ctrl;
  import usb_transaction_ctrl_pkg::*;

  localparam int NE = 2;
  localparam int TO = 32;
  localparam logic [6:0] ADDR = 7'd5;

  logic          clk;
  logic          reset_n;
  logic          bus_reset;
  logic [6:0]    dev_addr;
  logic          rx_tok_valid;
  logic [3:0]    rx_tok_pid;
  logic [6:0]    rx_tok_addr;
  logic [3:0]    rx_tok_endp;
  logic          rx_tok_crc_ok;
  logic          rx_data_valid;
  logic [3:0]    rx_data_pid;
  logic          rx_data_ok;
  logic [NE-1:0] ep_stall;
  logic [NE-1:0] ep_in_ready;
  logic [NE-1:0] ep_out_ready;
  logic          tx_req;
  logic [3:0]    tx_pid;
  logic          tx_with_data;
  logic          tx_done;
  logic [3:0]    xfer_endp;
  logic          setup_rcvd;
  logic          out_commit;
  logic          out_discard;
  logic          in_ack;
  logic          in_retry;

  usb_transaction_ctrl #(
    .NUM_ENDP (NE),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_reset     (bus_reset),
    .dev_addr      (dev_addr),
    .rx_tok_valid  (rx_tok_valid),
    .rx_tok_pid    (rx_tok_pid),
    .rx_tok_addr   (rx_tok_addr),
    .rx_tok_endp   (rx_tok_endp),
    .rx_tok_crc_ok (rx_tok_crc_ok),
    .rx_data_valid (rx_data_valid),
    .rx_data_pid   (rx_data_pid),
    .rx_data_ok    (rx_data_ok),
    .ep_stall      (ep_stall),
    .ep_in_ready   (ep_in_ready),
    .ep_out_ready  (ep_out_ready),
    .tx_req        (tx_req),
    .tx_pid        (tx_pid),
    .tx_with_data  (tx_with_data),
    .tx_done       (tx_done),
    .xfer_endp     (xfer_endp),
    .setup_rcvd    (setup_rcvd),
    .out_commit    (out_commit),
    .out_discard   (out_discard),
    .in_ack        (in_ack),
    .in_retry      (in_retry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int c_setup = 0, c_commit = 0, c_discard = 0;
  int c_ack = 0, c_retry = 0, c_txreq = 0, c_multi = 0;
  int s_setup, s_commit, s_discard, s_ack, s_retry, s_txreq;

  bit tog [NE];

  // Pulse and request activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (setup_rcvd)  c_setup++;
    if (out_commit)  c_commit++;
    if (out_discard) c_discard++;
    if (in_ack)      c_ack++;
    if (in_retry)    c_retry++;
    if (tx_req)      c_txreq++;
    if ($countones({setup_rcvd, out_commit, out_discard,
                    in_ack, in_retry}) > 1) c_multi++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_setup   = c_setup;
    s_commit  = c_commit;
    s_discard = c_discard;
    s_ack     = c_ack;
    s_retry   = c_retry;
    s_txreq   = c_txreq;
  endtask

  function automatic logic [19:0] pl(input int s, input int c,
      input int d, input int a, input int r);
    return {4'(s), 4'(c), 4'(d), 4'(a), 4'(r)};
  endfunction

  function automatic logic [19:0] pd();
    return {4'(c_setup - s_setup), 4'(c_commit - s_commit),
            4'(c_discard - s_discard), 4'(c_ack - s_ack),
            4'(c_retry - s_retry)};
  endfunction

  task automatic send_tok(input logic [3:0] pid, input logic [6:0] a,
                          input logic [3:0] e, input logic crc);
    rx_tok_valid  = 1'b1;
    rx_tok_pid    = pid;
    rx_tok_addr   = a;
    rx_tok_endp   = e;
    rx_tok_crc_ok = crc;
    cyc(1);
    rx_tok_valid  = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] pid, input logic ok);
    rx_data_valid = 1'b1;
    rx_data_pid   = pid;
    rx_data_ok    = ok;
    cyc(1);
    rx_data_valid = 1'b0;
  endtask

  task automatic hs_phase(input string tag, input logic [3:0] pid,
                          input logic wd);
    chk({tag, "/req"}, tx_req, 1);
    chk({tag, "/pid"}, tx_pid, pid);
    chk({tag, "/wd"}, tx_with_data, wd);
    cyc(2);
    chk({tag, "/hold"}, {tx_req, tx_pid}, {1'b1, pid});
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    chk({tag, "/drop"}, tx_req, 0);
  endtask

  // OUT or SETUP transaction; nodata lets the host stay silent.
  task automatic out_tx(input string tag, input bit setup, input int e,
      input logic [3:0] dp, input bit ok, input bit nodata,
      input bit st, input bit rd);
    logic [3:0]  hs;
    logic [19:0] ep;
    logic [3:0]  want;
    hs   = PID_RESERVED;
    ep   = pl(0, 0, 1, 0, 0);
    want = tog[e] ? PID_DATA1 : PID_DATA0;
    if (nodata || !ok || !(dp == PID_DATA0 || dp == PID_DATA1)) begin
      ep = pl(0, 0, 1, 0, 0);
    end else if (setup) begin
      if (dp == PID_DATA0) begin
        tog[e] = 1'b1;
        hs = PID_ACK;
        ep = pl(1, 0, 0, 0, 0);
      end
    end else if (st) begin
      hs = PID_STALL;
    end else if (!rd) begin
      hs = PID_NAK;
    end else if (dp == want) begin
      tog[e] = !tog[e];
      hs = PID_ACK;
      ep = pl(0, 1, 0, 0, 0);
    end else begin
      hs = PID_ACK;
    end
    ep_stall[e]     = st;
    ep_out_ready[e] = rd;
    snap();
    send_tok(setup ? PID_SETUP : PID_OUT, ADDR, 4'(e), 1'b1);
    cyc(2);
    chk({tag, "/endp"}, xfer_endp, e);
    if (nodata) cyc(TO + 3);
    else send_data(dp, ok);
    if (hs != PID_RESERVED) hs_phase(tag, hs, 1'b0);
    else chk({tag, "/nohs"}, tx_req, 0);
    cyc(1);
    chk({tag, "/pulse"}, pd(), ep);
  endtask

  // IN transaction; host 0=ACK, 1=silent, 2=bad reply.
  task automatic in_tx(input string tag, input int e, input bit st,
      input bit rd, input int host);
    logic [3:0]  pid;
    logic [19:0] ep;
    bit          data;
    data = 1'b0;
    ep   = pl(0, 0, 0, 0, 0);
    if (st) begin
      pid = PID_STALL;
    end else if (!rd) begin
      pid = PID_NAK;
    end else begin
      data = 1'b1;
      pid  = tog[e] ? PID_DATA1 : PID_DATA0;
      if (host == 0) begin
        tog[e] = !tog[e];
        ep = pl(0, 0, 0, 1, 0);
      end else begin
        ep = pl(0, 0, 0, 0, 1);
      end
    end
    ep_stall[e]    = st;
    ep_in_ready[e] = rd;
    snap();
    send_tok(PID_IN, ADDR, 4'(e), 1'b1);
    chk({tag, "/endp"}, xfer_endp, e);
    hs_phase(tag, pid, data);
    if (data) begin
      if (host == 0) begin
        cyc(2);
        send_data(PID_ACK, 1'b1);
      end else if (host == 1) begin
        cyc(TO - 1);
        chk({tag, "/early"}, c_retry - s_retry, 0);
        cyc(2);
      end else if ($urandom_range(0, 1) == 0) begin
        send_data(PID_NAK, 1'b1);
      end else begin
        send_data(PID_ACK, 1'b0);
      end
    end
    cyc(1);
    chk({tag, "/pulse"}, pd(), ep);
  endtask

  // Token that must be ignored, followed by a valid data packet.
  task automatic bogus(input string tag, input logic [3:0] pid,
      input logic [6:0] a, input logic [3:0] e, input logic crc);
    ep_stall     = '0;
    ep_out_ready = '1;
    ep_in_ready  = '1;
    snap();
    send_tok(pid, a, e, crc);
    cyc(2);
    send_data(PID_DATA0, 1'b1);
    cyc(3);
    chk({tag, "/txreq"}, c_txreq - s_txreq, 0);
    chk({tag, "/pulse"}, pd(), 0);
  endtask

  initial begin
    logic [3:0] dtab [5];
    int kind, e, v, host;
    bit st, rd, ok, nd;
    dtab[0] = PID_DATA0;
    dtab[1] = PID_DATA1;
    dtab[2] = PID_DATA0;
    dtab[3] = PID_DATA1;
    dtab[4] = PID_ACK;
    for (int i = 0; i < NE; i++) tog[i] = 1'b0;

    reset_n       = 1'b0;
    bus_reset     = 1'b0;
    dev_addr      = ADDR;
    rx_tok_valid  = 1'b0;
    rx_tok_pid    = 4'h0;
    rx_tok_addr   = 7'h0;
    rx_tok_endp   = 4'h0;
    rx_tok_crc_ok = 1'b0;
    rx_data_valid = 1'b0;
    rx_data_pid   = 4'h0;
    rx_data_ok    = 1'b0;
    ep_stall      = '0;
    ep_in_ready   = '0;
    ep_out_ready  = '0;
    tx_done       = 1'b0;
    cyc(3);
    chk("rst/req", tx_req, 0);
    chk("rst/pid", tx_pid, PID_RESERVED);
    chk("rst/wd", tx_with_data, 0);
    chk("rst/endp", xfer_endp, 0);
    chk("rst/pulse",
        {setup_rcvd, out_commit, out_discard, in_ack, in_retry}, 0);
    reset_n = 1'b1;
    cyc(2);

    out_tx("out1", 0, 1, PID_DATA0, 1, 0, 0, 1);
    out_tx("out1_rep", 0, 1, PID_DATA0, 1, 0, 0, 1);
    out_tx("setup0", 1, 0, PID_DATA0, 1, 0, 1, 0);
    in_tx("in0_d1", 0, 0, 1, 0);
    in_tx("in1_stall", 1, 1, 1, 0);
    in_tx("in1_nak", 1, 0, 0, 0);
    in_tx("in1_tmo", 1, 0, 1, 1);
    in_tx("in1_retry", 1, 0, 1, 0);
    in_tx("in1_bad", 1, 0, 1, 2);
    out_tx("out_badcrc", 0, 0, PID_DATA0, 0, 0, 0, 1);
    out_tx("out_tmo", 0, 0, PID_DATA0, 1, 1, 0, 1);
    out_tx("out_nak", 0, 1, PID_DATA1, 1, 0, 0, 0);
    out_tx("out_stall", 0, 1, PID_DATA0, 1, 0, 1, 1);
    out_tx("setup_d1", 1, 1, PID_DATA1, 1, 0, 0, 1);
    bogus("tok_addr", PID_OUT, 7'd6, 4'd1, 1'b1);
    bogus("tok_crc", PID_OUT, ADDR, 4'd1, 1'b0);
    bogus("tok_endp", PID_OUT, ADDR, 4'(NE), 1'b1);
    bogus("tok_sof", PID_SOF, ADDR, 4'd0, 1'b1);
    bogus("tok_in_addr", PID_IN, 7'd6, 4'd0, 1'b1);

    out_tx("setup_b", 1, 0, PID_DATA0, 1, 0, 0, 1);
    ep_stall[1]    = 1'b0;
    ep_in_ready[1] = 1'b1;
    snap();
    send_tok(PID_IN, ADDR, 4'd1, 1'b1);
    chk("brst/req", tx_req, 1);
    chk("brst/pid", tx_pid, tog[1] ? PID_DATA1 : PID_DATA0);
    bus_reset = 1'b1;
    cyc(1);
    bus_reset = 1'b0;
    for (int i = 0; i < NE; i++) tog[i] = 1'b0;
    chk("brst/drop", {tx_req, tx_with_data}, 0);
    chk("brst/endp", xfer_endp, 0);
    cyc(TO + 3);
    chk("brst/pulse", pd(), 0);
    in_tx("brst_in0", 0, 0, 1, 0);
    in_tx("brst_in1", 1, 0, 1, 0);

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 3);
      e    = $urandom_range(0, NE - 1);
      st   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 3) != 0);
      ok   = ($urandom_range(0, 7) != 0);
      nd   = ($urandom_range(0, 9) == 0);
      host = $urandom_range(0, 2);
      v    = $urandom_range(0, 4);
      case (kind)
        0: out_tx("r_out", 0, e, dtab[v], ok, nd, st, rd);
        1: out_tx("r_setup", 1, e, dtab[v], ok, nd, st, rd);
        2: in_tx("r_in", e, st, rd, host);
        default: begin
          case (v % 4)
            0: bogus("r_addr", PID_OUT, 7'd6, 4'(e), 1'b1);
            1: bogus("r_crc", PID_OUT, ADDR, 4'(e), 1'b0);
            2: bogus("r_endp", PID_OUT, ADDR, 4'(NE), 1'b1);
            default: bogus("r_sof", PID_SOF, ADDR, 4'(e), 1'b1);
          endcase
        end
      endcase
    end

    chk("excl", c_multi, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
